// File: rtl/snail_pkg.sv
// Shared types and constants for the snail pattern generator.
package snail_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } gen_state_e;

  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/snail_pattern_shreg.sv
// Loadable MSB-first left-shift register; msb_next exposes the value msb takes after this edge.
module snail_pattern_shreg #(
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] load_value,
  output logic               msb,
  output logic               msb_next
);

  logic [MAX_LEN-1:0] q;
  logic [MAX_LEN-1:0] q_next;

  always_comb begin
    q_next = q;
    if (load)
      q_next = load_value;
    else if (shift)
      q_next = {q[MAX_LEN-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    q <= q_next;
  end

  assign msb      = q[MAX_LEN-1];
  assign msb_next = q_next[MAX_LEN-1];

endmodule

// File: rtl/snail_pattern_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first on en ticks,
// with repetitions separated by idle gaps, under a start/busy/done handshake.
module snail_pattern_gen
  import snail_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [MAX_LEN-1:0]           pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  input  logic [REP_W-1:0]             repeat_cnt,
  input  logic [GAP_W-1:0]             gap,
  input  logic                         abort,
  output logic                         a,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = $clog2(MAX_LEN+1);

  gen_state_e         state_q, state_n;
  logic [LEN_W-1:0]   bits_q, bits_n;
  logic [REP_W-1:0]   reps_q, reps_n;
  logic [GAP_W-1:0]   gapl_q, gapl_n;
  logic [MAX_LEN-1:0] pat_q, pat_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [GAP_W-1:0]   gcfg_q, gcfg_n;
  logic               a_q, busy_q, done_q;

  logic               sr_load, sr_shift;
  logic [MAX_LEN-1:0] sr_value;
  logic               sr_msb, sr_msb_next;
  logic [LEN_W-1:0]   len_c;
  logic [LEN_W-1:0]   shamt;

  snail_pattern_shreg #(.MAX_LEN(MAX_LEN)) u_shreg (
    .clk        (clk),
    .load       (sr_load),
    .shift      (sr_shift),
    .load_value (sr_value),
    .msb        (sr_msb),
    .msb_next   (sr_msb_next)
  );

  always_comb begin
    state_n  = state_q;
    bits_n   = bits_q;
    reps_n   = reps_q;
    gapl_n   = gapl_q;
    pat_n    = pat_q;
    len_n    = len_q;
    gcfg_n   = gcfg_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_value = pat_q;
    len_c    = len;
    if (len > LEN_W'(MAX_LEN))
      len_c = LEN_W'(MAX_LEN);
    shamt = LEN_W'(MAX_LEN) - len_c;

    if (abort && state_q != IDLE) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            len_n  = len_c;
            pat_n  = pattern << shamt;
            reps_n = repeat_cnt;
            gcfg_n = gap;
            gapl_n = '0;
            if (len_c == '0) begin
              state_n = DONE;
            end else begin
              sr_load  = 1'b1;
              sr_value = pattern << shamt;
              bits_n   = len_c;
              state_n  = SEND;
            end
          end
        end
        SEND: begin
          if (en) begin
            if (bits_q > LEN_W'(1)) begin
              sr_shift = 1'b1;
              bits_n   = bits_q - LEN_W'(1);
            end else if (reps_q == '0) begin
              bits_n  = '0;
              state_n = DONE;
            end else if (gcfg_q == '0) begin
              // back-to-back copy: reload without an idle bit
              sr_load = 1'b1;
              bits_n  = len_q;
              reps_n  = reps_q - REP_W'(1);
            end else begin
              bits_n  = '0;
              gapl_n  = gcfg_q;
              state_n = GAP;
            end
          end
        end
        GAP: begin
          if (en) begin
            if (gapl_q > GAP_W'(1)) begin
              gapl_n = gapl_q - GAP_W'(1);
            end else begin
              gapl_n  = '0;
              sr_load = 1'b1;
              bits_n  = len_q;
              reps_n  = reps_q - REP_W'(1);
              state_n = SEND;
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // registered outputs follow the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      bits_q  <= '0;
      reps_q  <= '0;
      gapl_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      gcfg_q  <= '0;
      a_q     <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      bits_q  <= bits_n;
      reps_q  <= reps_n;
      gapl_q  <= gapl_n;
      pat_q   <= pat_n;
      len_q   <= len_n;
      gcfg_q  <= gcfg_n;
      a_q     <= (state_n == SEND) ? sr_msb_next : IDLE_LEVEL;
      busy_q  <= (state_n != IDLE);
      done_q  <= (state_n == DONE);
    end
  end

  assign a    = a_q;
  assign busy = busy_q;
  assign done = done_q;

  logic unused_msb;
  assign unused_msb = sr_msb;

endmodule

// File: tb/tb_snail_pattern_gen.sv
// Directed bench for snail_pattern_gen with a bench-side 1011 detector.
module tb_snail_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] repeat_cnt;
  logic [2:0] gap;
  logic       abort;
  logic       a, busy, done;

  int total = 0;
  int bad   = 0;

  int          nbits, busy_cyc, done_cnt, hits;
  logic [31:0] stream;

  snail_pattern_gen #(.MAX_LEN(8), .REP_W(4), .GAP_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .abort      (abort),
    .a          (a),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a transfer and captures the consumed bits until the DUT is idle.
  task automatic xfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                      input logic [2:0] g, input int per);
    logic [3:0] hist;
    pattern = p; len = l; repeat_cnt = r; gap = g; start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0;
    // scramble inputs: the latched configuration must not follow them
    pattern = ~p; len = 4'd8; repeat_cnt = 4'd7; gap = 3'd5;
    nbits = 0; busy_cyc = 0; done_cnt = 0; hits = 0; stream = '0; hist = '0;
    for (int k = 1; k < 400; k++) begin
      if (!busy) break;
      busy_cyc++;
      if (done) done_cnt++;
      en = ((k % per) == 0);
      if (en && !done) begin
        stream = {stream[30:0], a};
        nbits++;
        hist = {hist[2:0], a};
        if (hist == 4'b1011) hits++;
      end
      tick();
    end
    en = 1'b0;
    chk("xfer_ends_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; repeat_cnt = '0; gap = '0;
    tick(); tick();
    chk("rst_a", a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    tick();

    // single 1011
    xfer(8'b0000_1011, 4'd4, 4'd0, 3'd0, 1);
    chk("t1_stream", stream, 32'b1011);
    chk("t1_nbits", nbits, 4);
    chk("t1_busy", busy_cyc, 5);
    chk("t1_done", done_cnt, 1);
    chk("t1_hits", hits, 1);

    // three copies, gap 2, en every 3rd cycle
    xfer(8'b0000_1011, 4'd4, 4'd2, 3'd2, 3);
    chk("t2_stream", stream, 32'b1011_00_1011_00_1011);
    chk("t2_nbits", nbits, 16);
    chk("t2_busy", busy_cyc, 49);
    chk("t2_done", done_cnt, 1);
    chk("t2_hits", hits, 3);

    // back-to-back copies
    xfer(8'b0000_1011, 4'd4, 4'd1, 3'd0, 1);
    chk("t3_stream", stream, 32'b1011_1011);
    chk("t3_busy", busy_cyc, 9);
    chk("t3_hits", hits, 2);

    // len=0
    xfer(8'b1111_1111, 4'd0, 4'd0, 3'd0, 1);
    chk("t4_nbits", nbits, 0);
    chk("t4_busy", busy_cyc, 1);
    chk("t4_done", done_cnt, 1);

    // len clamped to 8
    xfer(8'hA5, 4'd15, 4'd0, 3'd0, 1);
    chk("t5_stream", stream, 32'hA5);
    chk("t5_nbits", nbits, 8);
    chk("t5_busy", busy_cyc, 9);

    // abort on the 2nd bit; mid-transfer start ignored
    pattern = 8'b0000_1011; len = 4'd4; repeat_cnt = '0; gap = '0;
    en = 1'b1; start = 1'b1;
    tick();
    chk("ab_bit1", a, 1);
    pattern = 8'hFF; len = 4'd8;
    tick();
    chk("ab_bit2", a, 0);
    chk("ab_busy_mid", busy, 1);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; en = 1'b0;
    chk("ab_a", a, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    xfer(8'b0000_1011, 4'd4, 4'd0, 3'd0, 1);
    chk("ab_re_stream", stream, 32'b1011);
    chk("ab_re_done", done_cnt, 1);

    // abort together with start in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abst_busy", busy, 0);

    // reset mid-GAP
    pattern = 8'b0000_1011; len = 4'd4; repeat_cnt = 4'd2; gap = 3'd2;
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rg_in_gap_a", a, 0);
    chk("rg_in_gap_busy", busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rg_a", a, 0);
    chk("rg_busy", busy, 0);
    chk("rg_done", done, 0);
    tick();
    chk("rg_after_busy", busy, 0);
    chk("rg_after_done", done, 0);
    rst = 1'b0; start = 1'b1;
    tick();
    rst = 1'b1; start = 1'b0;
    chk("rs_busy", busy, 0);
    tick();
    chk("rs_after_busy", busy, 0);
    chk("rs_after_a", a, 0);
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
